data_mem_responder: RTL and testbench

- Responder end of the load/store unit's memory request interface: single-outstanding data memory model with configurable access latency.
- Accepts one load or store request via a valid/ready handshake and holds ready low while busy.
- After a fixed latency, performs the access on an internal word array and returns a one-cycle ack carrying load data.
- Sits below the memory controller; drives memory_ready, memory_ack and memory_data_return.

---
 rtl/data_mem_responder.sv | 85 ++++++++
 tb/tb_data_mem_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data memory responder with a fixed access latency.
// Requests are accepted in IDLE, performed on the edge entering ACK, and acknowledged for one cycle.
package data_mem_pkg;
   localparam int REG_VAL_WIDTH = 32;
   localparam int D_MEMORY_ADDR_WIDTH = 32;
   typedef enum logic [1:0] {
      MEM_INVALID = 2'd0,
      MEM_LOAD    = 2'd1,
      MEM_STORE   = 2'd2,
      MEM_RSVD    = 2'd3
   } memory_op_t;
endpackage

module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int DEPTH   = 256
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           memory_req_valid,
   input  memory_op_t                     memory_req_op,
   input  logic [D_MEMORY_ADDR_WIDTH-1:0] memory_req_address,
   input  logic [REG_VAL_WIDTH-1:0]       memory_req_data,
   output logic                           memory_ready,
   output logic                           memory_ack,
   output logic [REG_VAL_WIDTH-1:0]       memory_data_return
);
   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;

   state_t                   r_state;
   logic [3:0]               r_cnt;
   memory_op_t               r_op;
   logic [IW-1:0]            r_idx;
   logic [REG_VAL_WIDTH-1:0] r_data;
   logic [REG_VAL_WIDTH-1:0] r_mem [DEPTH];

   logic                     w_idle;
   logic                     w_access;
   memory_op_t               w_op;
   logic [IW-1:0]            w_idx;
   logic [REG_VAL_WIDTH-1:0] w_data;

   assign w_idle       = r_state == S_IDLE;
   assign memory_ready = w_idle;
   // With LATENCY=1 the access happens on the accept edge itself, so it uses the live request.
   assign w_access     = (r_state == S_BUSY && r_cnt == 4'd0) ||
                         (LATENCY == 1 && w_idle && memory_req_valid);
   assign w_op         = w_idle ? memory_req_op : r_op;
   assign w_idx        = w_idle ? IW'(memory_req_address) : r_idx;
   assign w_data       = w_idle ? memory_req_data : r_data;

   // Array has no reset so contents survive it; a reset edge suppresses any pending write.
   always_ff @(posedge clk)
      if (reset && w_access && w_op == MEM_STORE) r_mem[w_idx] <= w_data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state            <= S_IDLE;
         r_cnt              <= '0;
         memory_ack         <= 1'b0;
         memory_data_return <= '0;
      end else begin
         memory_ack         <= w_access;
         memory_data_return <= (w_access && w_op == MEM_LOAD) ? r_mem[w_idx] : '0;
         case (r_state)
            S_IDLE:
               if (memory_req_valid) begin
                  r_op    <= memory_req_op;
                  r_idx   <= w_idx;
                  r_data  <= memory_req_data;
                  r_cnt   <= 4'(LATENCY - 1);
                  r_state <= (LATENCY == 1) ? S_ACK : S_BUSY;
               end
            S_BUSY:
               if (r_cnt == 4'd0) r_state <= S_ACK;
               else r_cnt <= r_cnt - 4'd1;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized checks of two responders (LATENCY=2 and LATENCY=1)
// against a plain array model of the memory and the accept-to-ack timing rules.
module tb_data_mem_responder;
   import data_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        v [2];
   memory_op_t  op [2];
   logic [31:0] a [2];
   logic [31:0] wd [2];
   logic [31:0] dr [2];
   logic        rdy [2];
   logic        ak [2];

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [31:0] mdl [2][256];
   bit          wr [2][256];

   int          t_lat;
   bit          t_to;
   logic [31:0] t_got;
   logic        t_rdy_low, t_ack_after, t_rdy_after;
   logic [31:0] t_dr_after;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_responder #(.LATENCY(2), .DEPTH(256)) d2 (
      .clk(clk), .reset(reset),
      .memory_req_valid(v[0]), .memory_req_op(op[0]),
      .memory_req_address(a[0]), .memory_req_data(wd[0]),
      .memory_ready(rdy[0]), .memory_ack(ak[0]), .memory_data_return(dr[0]));

   data_mem_responder #(.LATENCY(1), .DEPTH(256)) d1 (
      .clk(clk), .reset(reset),
      .memory_req_valid(v[1]), .memory_req_op(op[1]),
      .memory_req_address(a[1]), .memory_req_data(wd[1]),
      .memory_ready(rdy[1]), .memory_ack(ak[1]), .memory_data_return(dr[1]));

   function automatic int lat_of(int s);
      return (s == 0) ? 2 : 1;
   endfunction

   // Edges between the accept edge and the ack cycle: LATENCY, except LATENCY=1 acks right after accept.
   function automatic int edges_of(int s);
      return (lat_of(s) == 1) ? 0 : lat_of(s);
   endfunction

   function automatic int spacing_of(int s);
      return edges_of(s) + 2;
   endfunction

   task automatic model(input int s, input memory_op_t o, input logic [31:0] ad,
                        input logic [31:0] d, output logic [31:0] e);
      int idx = int'(ad % 256);
      e = '0;
      if (o == MEM_LOAD) e = mdl[s][idx];
      else if (o == MEM_STORE) begin
         mdl[s][idx] = d;
         wr[s][idx] = 1'b1;
      end
   endtask

   task automatic run_req(input int s, input memory_op_t o, input logic [31:0] ad, input logic [31:0] d);
      int n = 0;
      @(negedge clk);
      v[s] = 1'b1; op[s] = o; a[s] = ad; wd[s] = d;
      while (!rdy[s] && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      v[s] = 1'b0;
      op[s] = memory_op_t'(2'($urandom_range(0, 3)));
      a[s] = ad;
      wd[s] = $urandom;
      t_rdy_low = !rdy[s];
      t_lat = 0;
      while (!ak[s] && t_lat < 40) begin
         @(posedge clk);
         #1;
         t_lat++;
      end
      t_to = !ak[s];
      t_got = dr[s];
      @(posedge clk);
      #1;
      t_ack_after = ak[s];
      t_dr_after = dr[s];
      t_rdy_after = rdy[s];
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int s = 0; s < 2; s++) begin
         v[s] = 1'b0; op[s] = MEM_INVALID; a[s] = '0; wd[s] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (rdy[s] !== 1'b1 || ak[s] !== 1'b0 || dr[s] !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs dut%0d: ready=%b ack=%b data=%h expected 1 0 0", s, rdy[s], ak[s], dr[s]);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         for (int s = 0; s < 2; s++) begin
            checks++;
            if (rdy[s] !== 1'b1 || ak[s] !== 1'b0 || dr[s] !== 32'h0) begin
               failures++;
               $display("FAIL idle_quiet dut%0d cycle %0d: ready=%b ack=%b data=%h expected 1 0 0", s, c, rdy[s], ak[s], dr[s]);
            end
         end
      end
   endtask

   task automatic test_store_load(input int s);
      logic [31:0] e;
      model(s, MEM_STORE, 32'h10, 32'hDEADBEEF, e);
      run_req(s, MEM_STORE, 32'h10, 32'hDEADBEEF);
      checks++;
      if (t_to || t_lat !== edges_of(s)) begin
         failures++;
         $display("FAIL store_ack_timing dut%0d: edges=%0d timeout=%0d expected %0d", s, t_lat, t_to, edges_of(s));
      end
      checks++;
      if (t_rdy_low !== 1'b1) begin
         failures++;
         $display("FAIL store_ready_low dut%0d: ready_low=%b expected 1", s, t_rdy_low);
      end
      checks++;
      if (t_got !== e) begin
         failures++;
         $display("FAIL store_ack_data dut%0d: got %h expected %h", s, t_got, e);
      end
      checks++;
      if (t_ack_after !== 1'b0 || t_rdy_after !== 1'b1) begin
         failures++;
         $display("FAIL store_after_ack dut%0d: ack=%b ready=%b expected 0 1", s, t_ack_after, t_rdy_after);
      end
      model(s, MEM_LOAD, 32'h10, 32'h0, e);
      run_req(s, MEM_LOAD, 32'h10, 32'h0);
      checks++;
      if (t_to || t_lat !== edges_of(s)) begin
         failures++;
         $display("FAIL load_ack_timing dut%0d: edges=%0d timeout=%0d expected %0d", s, t_lat, t_to, edges_of(s));
      end
      checks++;
      if (t_got !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL load_data dut%0d: got %h expected %h", s, t_got, 32'hDEADBEEF);
      end
      checks++;
      if (t_dr_after !== 32'h0 || t_ack_after !== 1'b0) begin
         failures++;
         $display("FAIL load_after_ack dut%0d: data=%h ack=%b expected 0 0", s, t_dr_after, t_ack_after);
      end
   endtask

   task automatic test_alias(input int s);
      logic [31:0] e;
      model(s, MEM_STORE, 32'h105, 32'h1234, e);
      run_req(s, MEM_STORE, 32'h105, 32'h1234);
      model(s, MEM_LOAD, 32'h005, 32'h0, e);
      run_req(s, MEM_LOAD, 32'h005, 32'h0);
      checks++;
      if (t_to || t_got !== 32'h1234) begin
         failures++;
         $display("FAIL alias_load dut%0d: got %h timeout=%0d expected %h", s, t_got, t_to, 32'h1234);
      end
   endtask

   task automatic test_random(input int s);
      logic [31:0] e, ad, d;
      memory_op_t o;
      for (int i = 0; i < 25; i++) begin
         o = memory_op_t'(2'($urandom_range(0, 3)));
         ad = 32'($urandom_range(0, 1023));
         d = $urandom;
         if (o == MEM_LOAD && !wr[s][ad % 256]) o = MEM_STORE;
         model(s, o, ad, d, e);
         run_req(s, o, ad, d);
         checks++;
         if (t_to || t_lat !== edges_of(s) || t_got !== e || t_dr_after !== 32'h0) begin
            failures++;
            $display("FAIL random_txn dut%0d #%0d op=%0d addr=%h: edges=%0d data=%h after=%h expected edges=%0d data=%h after=0",
                     s, i, o, ad, t_lat, t_got, t_dr_after, edges_of(s), e);
         end
      end
   endtask

   task automatic test_back_to_back(input int s);
      int acc[$];
      logic [31:0] expq[$];
      logic [31:0] e, ad, d;
      memory_op_t o;
      int n = 0;
      int k = 0;
      while ((k < 6 || expq.size() > 0) && n < 200) begin
         @(negedge clk);
         n++;
         if (ak[s]) begin
            checks++;
            if (expq.size() == 0) begin
               failures++;
               $display("FAIL b2b_spurious_ack dut%0d: ack=1 expected none", s);
            end else begin
               e = expq.pop_front();
               if (dr[s] !== e) begin
                  failures++;
                  $display("FAIL b2b_data dut%0d: got %h expected %h", s, dr[s], e);
               end
            end
         end
         if (rdy[s] && k < 6) begin
            o = (k % 2 == 1) ? MEM_LOAD : MEM_STORE;
            ad = (k % 2 == 1) ? 32'h140 : 32'h40;
            d = $urandom;
            model(s, o, ad, d, e);
            expq.push_back(e);
            acc.push_back(cyc);
            v[s] = 1'b1; op[s] = o; a[s] = ad; wd[s] = d;
            k++;
         end else begin
            v[s] = (k < 6);
            op[s] = memory_op_t'(2'($urandom_range(0, 3)));
            a[s] = 32'h40;
            wd[s] = $urandom;
         end
      end
      v[s] = 1'b0;
      checks++;
      if (k !== 6 || expq.size() !== 0) begin
         failures++;
         $display("FAIL b2b_complete dut%0d: accepted=%0d pending=%0d expected 6 0", s, k, expq.size());
      end
      for (int i = 1; i < acc.size(); i++) begin
         checks++;
         if (acc[i] - acc[i-1] !== spacing_of(s)) begin
            failures++;
            $display("FAIL b2b_spacing dut%0d #%0d: got %0d expected %0d", s, i, acc[i] - acc[i-1], spacing_of(s));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      int spurious = 0;
      model(0, MEM_STORE, 32'h20, 32'h55, e);
      run_req(0, MEM_STORE, 32'h20, 32'h55);
      @(negedge clk);
      v[0] = 1'b1; op[0] = MEM_STORE; a[0] = 32'h20; wd[0] = 32'hAA;
      @(posedge clk);
      #1;
      v[0] = 1'b0;
      checks++;
      if (rdy[0] !== 1'b0) begin
         failures++;
         $display("FAIL midreset_accept: ready=%b expected 0", rdy[0]);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (rdy[0] !== 1'b1 || ak[0] !== 1'b0 || dr[0] !== 32'h0) begin
         failures++;
         $display("FAIL midreset_outputs: ready=%b ack=%b data=%h expected 1 0 0", rdy[0], ak[0], dr[0]);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (ak[0] !== 1'b0) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         failures++;
         $display("FAIL midreset_no_ack: acks=%0d expected 0", spurious);
      end
      model(0, MEM_LOAD, 32'h20, 32'h0, e);
      run_req(0, MEM_LOAD, 32'h20, 32'h0);
      checks++;
      if (t_to || t_got !== e) begin
         failures++;
         $display("FAIL midreset_load: got %h timeout=%0d expected %h", t_got, t_to, e);
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         v[s] = 1'b0; op[s] = MEM_INVALID; a[s] = '0; wd[s] = '0;
      end
      test_reset();
      for (int s = 0; s < 2; s++) begin
         test_store_load(s);
         test_alias(s);
         test_random(s);
         test_back_to_back(s);
      end
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
